// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, operand source
// selects, the resolved issue entry and its reset value.
// Optional feature macro used by the stage: ALU_ISSUE_BYPASS_EN.
package alu_issue_stage_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_e;

    typedef struct packed {
        word_t            a;
        word_t            b;
        alu_op_e          op;
        logic [RA_W-1:0]  rd;
    } issue_entry_t;

    localparam issue_entry_t RESET_ENTRY = '{a: '0, b: '0, op: ALU_OP_ADD, rd: '0};

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_stage_fwd.sv
// alu_issue_fwd: combinational bypass mux for one source operand.
//   rs_addr/rs_data     register index and register-file read data
//   slot_valid/slot_rd  output slot of the issue stage (producer candidate)
//   slot_leaving        downstream consumes the output slot this cycle
//   alu_result          ALU result for the output slot (source 1, highest priority)
//   wb_valid/wb_rd/wb_data  write-back port (source 2)
//   fwd_data            resolved operand
// Only elaborated when ALU_ISSUE_BYPASS_EN is defined.
module alu_issue_fwd #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            slot_valid,
    input  logic [RA_W-1:0] slot_rd,
    input  logic            slot_leaving,
    input  logic [XLEN-1:0] alu_result,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic nonzero;
    assign nonzero = (rs_addr != '0);

    always_comb begin
        fwd_data = rs_data;
        // The ALU result is only final when its producer is leaving the slot.
        if (nonzero && slot_valid && slot_leaving && (slot_rd == rs_addr)) begin
            fwd_data = alu_result;
        end else if (nonzero && wb_valid && (wb_rd == rs_addr)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage in front of the combinational ALU.
//   clk_in, rst_n_in (async, active low), flush_in (sync discard)
//   decode side : valid_in/ready_out, rs*_data_in, rs*_addr_in, pc_in, imm_in,
//                 src_a_sel_in, src_b_sel_in, op_in, rd_addr_in
//   ALU side    : valid_out/ready_in, a_out, b_out, op_out, rd_addr_out
//   bypass      : alu_result_in, wb_valid_in, wb_rd_in, wb_data_in
// Macro ALU_ISSUE_BYPASS_EN enables operand forwarding; without it the
// bypass inputs are ignored and register-file data is used directly.
// An output slot plus a one-entry skid register gives two entries of
// storage so that ready_out comes straight from a flop.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = alu_issue_stage_pkg::XLEN,
    parameter int RA_W = alu_issue_stage_pkg::RA_W
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [RA_W-1:0] rs1_addr_in,
    input  logic [RA_W-1:0] rs2_addr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [1:0]      src_a_sel_in,
    input  logic [1:0]      src_b_sel_in,
    input  alu_op_e         op_in,
    input  logic [RA_W-1:0] rd_addr_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] a_out,
    output logic [XLEN-1:0] b_out,
    output alu_op_e         op_out,
    output logic [RA_W-1:0] rd_addr_out,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic            wb_valid_in,
    input  logic [RA_W-1:0] wb_rd_in,
    input  logic [XLEN-1:0] wb_data_in
);

    issue_entry_t    out_q, skid_q, new_entry;
    logic            out_valid, skid_valid;
    logic            accept;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, b_sel;

`ifdef ALU_ISSUE_BYPASS_EN
    alu_issue_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr      (rs1_addr_in),
        .rs_data      (rs1_data_in),
        .slot_valid   (out_valid),
        .slot_rd      (out_q.rd),
        .slot_leaving (ready_in),
        .alu_result   (alu_result_in),
        .wb_valid     (wb_valid_in),
        .wb_rd        (wb_rd_in),
        .wb_data      (wb_data_in),
        .fwd_data     (rs1_fwd)
    );

    alu_issue_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr      (rs2_addr_in),
        .rs_data      (rs2_data_in),
        .slot_valid   (out_valid),
        .slot_rd      (out_q.rd),
        .slot_leaving (ready_in),
        .alu_result   (alu_result_in),
        .wb_valid     (wb_valid_in),
        .wb_rd        (wb_rd_in),
        .wb_data      (wb_data_in),
        .fwd_data     (rs2_fwd)
    );
`else
    assign rs1_fwd = rs1_data_in;
    assign rs2_fwd = rs2_data_in;

    // Bypass ports stay on the interface; the hazard unit stalls instead.
    logic unused_bypass;
    assign unused_bypass = ^{alu_result_in, wb_valid_in, wb_rd_in, wb_data_in};
`endif

    assign ready_out = !skid_valid;
    assign accept    = valid_in && ready_out;

    // Operands are resolved at accept time and stored resolved.
    always_comb begin
        new_entry = RESET_ENTRY;
        b_sel     = '0;
        case (alu_src_a_e'(src_a_sel_in))
            SRC_A_RS1: new_entry.a = rs1_fwd;
            SRC_A_PC:  new_entry.a = pc_in;
            default:   new_entry.a = '0;
        endcase
        case (alu_src_b_e'(src_b_sel_in))
            SRC_B_RS2:  b_sel = rs2_fwd;
            SRC_B_IMM:  b_sel = imm_in;
            SRC_B_FOUR: b_sel = XLEN'(4);
            default:    b_sel = '0;
        endcase
        new_entry.b  = is_shift(op_in) ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;
        new_entry.op = op_in;
        new_entry.rd = rd_addr_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid  <= 1'b0;
            out_q      <= RESET_ENTRY;
            skid_valid <= 1'b0;
            skid_q     <= RESET_ENTRY;
        end else if (flush_in) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || ready_in) begin
            // Slot is free or draining: the older skid entry goes first.
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= new_entry;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign valid_out   = out_valid;
    assign a_out       = out_q.a;
    assign b_out       = out_q.b;
    assign op_out      = out_q.op;
    assign rd_addr_out = out_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_in, valid_in, ready_out, valid_out, ready_in;
    logic [31:0] rs1_data_in, rs2_data_in, pc_in, imm_in;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in, rd_addr_out, wb_rd_in;
    logic [1:0]  src_a_sel_in, src_b_sel_in;
    alu_op_e     op_in, op_out;
    logic [31:0] a_out, b_out, alu_result_in, wb_data_in;
    logic        wb_valid_in;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .pc_in(pc_in), .imm_in(imm_in),
        .src_a_sel_in(src_a_sel_in), .src_b_sel_in(src_b_sel_in),
        .op_in(op_in), .rd_addr_in(rd_addr_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .a_out(a_out), .b_out(b_out), .op_out(op_out), .rd_addr_out(rd_addr_out),
        .alu_result_in(alu_result_in), .wb_valid_in(wb_valid_in),
        .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference forwarding: newest producer is the instruction leaving the stage.
    function automatic logic [31:0] mfwd(input logic [4:0] addr, input logic [31:0] data);
`ifdef ALU_ISSUE_BYPASS_EN
        if (addr != 0 && q.size() > 0 && ready_in && q[0].rd == addr) return alu_result_in;
        if (addr != 0 && wb_valid_in && wb_rd_in == addr) return wb_data_in;
`endif
        return data;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(valid_out), 32'(q.size() > 0));
        chk({tag, ".ready"}, 32'(ready_out), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".a"},  a_out,            q[0].a);
            chk({tag, ".b"},  b_out,            q[0].b);
            chk({tag, ".op"}, 32'(op_out),      32'(q[0].op));
            chk({tag, ".rd"}, 32'(rd_addr_out), 32'(q[0].rd));
        end
    endtask

    // One clock: predict with the model, clock the DUT, compare on the negedge.
    task automatic step(input string tag);
        exp_t e;
        bit   acc, adv;
        logic [31:0] bv;
        acc = valid_in && (q.size() < 2) && !flush_in;
        adv = (q.size() > 0) && ready_in;
        case (src_a_sel_in)
            2'd0:    e.a = mfwd(rs1_addr_in, rs1_data_in);
            2'd1:    e.a = pc_in;
            default: e.a = 32'd0;
        endcase
        case (src_b_sel_in)
            2'd0:    bv = mfwd(rs2_addr_in, rs2_data_in);
            2'd1:    bv = imm_in;
            2'd2:    bv = 32'd4;
            default: bv = 32'd0;
        endcase
        if (op_in == ALU_OP_SLL || op_in == ALU_OP_SRL || op_in == ALU_OP_SRA)
            bv = bv % 32;
        e.b  = bv;
        e.op = op_in;
        e.rd = rd_addr_in;
        @(posedge clk);
        if (flush_in) q.delete();
        else begin
            if (adv) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_instr(input logic v, input logic [1:0] asel, input logic [1:0] bsel,
                             input alu_op_e op, input logic [4:0] r1, input logic [31:0] d1,
                             input logic [4:0] r2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] rd);
        valid_in     = v;
        src_a_sel_in = asel;
        src_b_sel_in = bsel;
        op_in        = op;
        rs1_addr_in  = r1;
        rs1_data_in  = d1;
        rs2_addr_in  = r2;
        rs2_data_in  = d2;
        imm_in       = imm;
        rd_addr_in   = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_in = 0; ready_in = 0; pc_in = 32'h1000;
        alu_result_in = 0; wb_valid_in = 0; wb_rd_in = 0; wb_data_in = 0;
        set_instr(0, 2'd0, 2'd0, ALU_OP_ADD, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        chk("rst.valid", 32'(valid_out), 0);
        chk("rst.ready", 32'(ready_out), 1);
        chk("rst.a", a_out, 0);
        chk("rst.b", b_out, 0);
        chk("rst.op", 32'(op_out), 32'(ALU_OP_ADD));
        chk("rst.rd", 32'(rd_addr_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ADD with register operands
        ready_in = 1;
        set_instr(1, 2'd0, 2'd0, ALU_OP_ADD, 1, 5, 2, 7, 0, 4);
        step("t1");
        chk("t1.a_dir", a_out, 5);
        chk("t1.b_dir", b_out, 7);
        chk("t1.valid_dir", 32'(valid_out), 1);
        valid_in = 0;
        step("t1.drain");

        // Back-pressure: two accepts while stalled, third offer refused
        ready_in = 0;
        set_instr(1, 2'd1, 2'd2, ALU_OP_ADD, 0, 0, 0, 0, 0, 6);
        pc_in = 32'h100;
        step("t2.a");
        pc_in = 32'h200;
        step("t2.b");
        chk("t2.ready_dir", 32'(ready_out), 0);
        pc_in = 32'h300;
        step("t2.c");
        chk("t2.hold_dir", a_out, 32'h100);
        valid_in = 0; ready_in = 1;
        step("t2.d");
        chk("t2.order_dir", a_out, 32'h200);
        step("t2.e");

        // Shift amount masking on the immediate
        set_instr(1, 2'd0, 2'd1, ALU_OP_SRL, 1, 9, 0, 0, 32'h0000_0423, 1);
        step("t3.srl");
        chk("t3.srl_b", b_out, 32'h3);
        set_instr(1, 2'd0, 2'd1, ALU_OP_ADD, 1, 9, 0, 0, 32'h0000_0423, 1);
        step("t3.add");
        chk("t3.add_b", b_out, 32'h423);
        valid_in = 0;
        step("t3.drain");

`ifdef ALU_ISSUE_BYPASS_EN
        set_instr(1, 2'd0, 2'd0, ALU_OP_ADD, 0, 1, 0, 1, 0, 3);
        step("t4.prod");
        alu_result_in = 32'hAA;
        set_instr(1, 2'd0, 2'd0, ALU_OP_ADD, 3, 32'h11, 0, 0, 0, 3);
        step("t4.alu");
        chk("t4.alu_dir", a_out, 32'hAA);
        wb_valid_in = 1; wb_rd_in = 3; wb_data_in = 32'hBB;
        step("t4.prio");
        chk("t4.prio_dir", a_out, 32'hAA);
        set_instr(1, 2'd0, 2'd0, ALU_OP_ADD, 0, 32'h55, 0, 0, 0, 3);
        step("t4.x0");
        chk("t4.x0_dir", a_out, 32'h55);
        valid_in = 0; wb_valid_in = 0;
        step("t4.drain");
`endif

        // Flush with skid full and a simultaneous offer
        ready_in = 0;
        set_instr(1, 2'd2, 2'd2, ALU_OP_OR, 0, 0, 0, 0, 0, 7);
        step("t5.x");
        step("t5.y");
        flush_in = 1;
        step("t5.flush");
        chk("t5.valid_dir", 32'(valid_out), 0);
        chk("t5.ready_dir", 32'(ready_out), 1);
        flush_in = 0; valid_in = 0; ready_in = 1;
        step("t5.after1");
        step("t5.after2");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            valid_in      = ($urandom_range(0, 3) != 0);
            ready_in      = ($urandom_range(0, 3) != 0);
            flush_in      = ($urandom_range(0, 31) == 0);
            src_a_sel_in  = 2'($urandom_range(0, 2));
            src_b_sel_in  = 2'($urandom_range(0, 2));
            op_in         = alu_op_e'(4'($urandom_range(0, 9)));
            rs1_addr_in   = 5'($urandom_range(0, 3));
            rs2_addr_in   = 5'($urandom_range(0, 3));
            rd_addr_in    = 5'($urandom_range(0, 3));
            rs1_data_in   = $urandom;
            rs2_data_in   = $urandom;
            pc_in         = $urandom;
            imm_in        = $urandom;
            alu_result_in = $urandom;
            wb_valid_in   = 1'($urandom_range(0, 1));
            wb_rd_in      = 5'($urandom_range(0, 3));
            wb_data_in    = $urandom;
            step("rnd");
        end

        // Asynchronous reset while an entry is held
        flush_in = 0; ready_in = 0;
        set_instr(1, 2'd1, 2'd2, ALU_OP_SUB, 0, 0, 0, 0, 0, 9);
        pc_in = 32'hDEAD;
        step("t6.fill");
        valid_in = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6.valid", 32'(valid_out), 0);
        chk("t6.ready", 32'(ready_out), 1);
        chk("t6.a", a_out, 0);
        chk("t6.b", b_out, 0);
        chk("t6.op", 32'(op_out), 32'(ALU_OP_ADD));
        chk("t6.rd", 32'(rd_addr_out), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
